ascon_controller: RTL and testbench

Sequencing FSM for the ASCON-AEAD128 encryption datapath. It drives the 320-bit state register's load enable and input select, the round-constant index, and the key, data and domain-separation XOR enables, so that one permutation round runs per clock. It accepts associated-data and plaintext blocks over a valid/ready handshake and flags ciphertext and tag availability. It sits beside the state register and permutation round and owns all of their control.

---
 rtl/ascon_controller.sv | 152 +++++++++++++++
 tb/tb_ascon_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ascon_controller.sv
// Control sequencer for the ASCON-AEAD128 encryption datapath: one permutation
// round per clock, valid/ready intake of AD and plaintext blocks, tag signalling.
module ascon_controller #(
   parameter int unsigned NB_ROUNDS_A = 12,
   parameter int unsigned NB_ROUNDS_B = 8
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       ad_empty_i,
   input  logic       block_valid_i,
   input  logic       block_last_i,
   output logic       block_ready_o,
   output logic       init_sel_o,
   output logic       state_en_o,
   output logic [3:0] round_o,
   output logic       xor_data_o,
   output logic       xor_key_begin_o,
   output logic       xor_key_end_o,
   output logic       xor_dsep_o,
   output logic       cipher_valid_o,
   output logic       tag_valid_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam logic [3:0] RND_LAST  = 4'(NB_ROUNDS_A - 1);
   localparam logic [3:0] RND_B_1ST = 4'(NB_ROUNDS_A - NB_ROUNDS_B);

   typedef enum logic [3:0] {
      IDLE, INIT_LOAD, INIT_RND, AD_WAIT, AD_RND, TXT_WAIT, TXT_RND, FIN_RND, TAG
   } state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       ad_empty_q;
   logic       last_q;

   logic accept;
   logic at_last;

   assign accept  = ((state == AD_WAIT) || (state == TXT_WAIT)) && block_valid_i;
   assign at_last = (cnt == RND_LAST);

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state      <= IDLE;
         cnt        <= '0;
         ad_empty_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (start_i) begin
                  ad_empty_q <= ad_empty_i;
                  state      <= INIT_LOAD;
               end
            end
            INIT_LOAD: begin
               cnt   <= '0;
               state <= INIT_RND;
            end
            INIT_RND: begin
               if (at_last) begin
                  cnt   <= '0;
                  state <= ad_empty_q ? TXT_WAIT : AD_WAIT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            AD_WAIT: begin
               // the accept cycle itself runs the first p^b round
               if (block_valid_i) begin
                  last_q <= block_last_i;
                  cnt    <= RND_B_1ST + 4'd1;
                  state  <= AD_RND;
               end
            end
            AD_RND: begin
               if (at_last) begin
                  cnt   <= '0;
                  state <= last_q ? TXT_WAIT : AD_WAIT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            TXT_WAIT: begin
               if (block_valid_i) begin
                  if (block_last_i) begin
                     cnt   <= 4'd1;
                     state <= FIN_RND;
                  end else begin
                     cnt   <= RND_B_1ST + 4'd1;
                     state <= TXT_RND;
                  end
               end
            end
            TXT_RND: begin
               if (at_last) begin
                  cnt   <= '0;
                  state <= TXT_WAIT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            FIN_RND: begin
               if (at_last) begin
                  cnt   <= '0;
                  state <= TAG;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            TAG: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Decodes of the registered state; the WAIT states also fold in the
   // same-cycle block handshake so a block is absorbed with no bubble.
   always_comb begin
      block_ready_o   = (state == AD_WAIT) || (state == TXT_WAIT);
      init_sel_o      = (state == INIT_LOAD);
      state_en_o      = (state == INIT_LOAD) || (state == INIT_RND) || (state == AD_RND) ||
                        (state == TXT_RND) || (state == FIN_RND) || accept;
      round_o         = '0;
      xor_data_o      = accept;
      cipher_valid_o  = (state == TXT_WAIT) && block_valid_i;
      xor_key_begin_o = (state == TXT_WAIT) && block_valid_i && block_last_i;
      xor_key_end_o   = ((state == INIT_RND) || (state == FIN_RND)) && at_last;
      xor_dsep_o      = ((state == INIT_RND) && at_last && ad_empty_q) ||
                        ((state == AD_RND) && at_last && last_q);
      tag_valid_o     = (state == TAG);
      done_o          = (state == TAG);
      busy_o          = (state != IDLE);

      if ((state == INIT_RND) || (state == AD_RND) || (state == TXT_RND) || (state == FIN_RND)) begin
         round_o = cnt;
      end else if (accept) begin
         round_o = xor_key_begin_o ? 4'd0 : RND_B_1ST;
      end
   end

endmodule

// File: tb/tb_ascon_controller.sv
// Self-checking bench for ascon_controller: directed reset abort, then directed and
// random messages compared cycle by cycle against an expected trace built per message.
module tb_ascon_controller;

   logic       clock_i = 1'b0;
   logic       resetb_i = 1'b0;
   logic       start_i = 1'b0;
   logic       ad_empty_i = 1'b0;
   logic       block_valid_i = 1'b0;
   logic       block_last_i = 1'b0;
   logic       block_ready_o, init_sel_o, state_en_o;
   logic [3:0] round_o;
   logic       xor_data_o, xor_key_begin_o, xor_key_end_o, xor_dsep_o;
   logic       cipher_valid_o, tag_valid_o, busy_o, done_o;

   ascon_controller #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(8)) dut (
      .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .ad_empty_i(ad_empty_i),
      .block_valid_i(block_valid_i), .block_last_i(block_last_i), .block_ready_o(block_ready_o),
      .init_sel_o(init_sel_o), .state_en_o(state_en_o), .round_o(round_o),
      .xor_data_o(xor_data_o), .xor_key_begin_o(xor_key_begin_o), .xor_key_end_o(xor_key_end_o),
      .xor_dsep_o(xor_dsep_o), .cipher_valid_o(cipher_valid_o), .tag_valid_o(tag_valid_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clock_i = ~clock_i;

   // Packed view: ready,init_sel,en,round[3:0],xdata,kbeg,kend,dsep,cv,tag,busy,done
   logic [14:0] obs;
   assign obs = {block_ready_o, init_sel_o, state_en_o, round_o, xor_data_o, xor_key_begin_o,
                 xor_key_end_o, xor_dsep_o, cipher_valid_o, tag_valid_o, busy_o, done_o};

   typedef struct packed {
      logic        start;
      logic        ae;
      logic        valid;
      logic        last;
      logic        rs;   // start_i may be randomised (controller not idle)
      logic        rv;   // block_valid_i may be randomised (controller not waiting)
      logic [14:0] exp;
   } rec_t;

   rec_t q[$];
   int   compares = 0;
   int   errs = 0;
   int   msg_no = 0;
   bit   hold = 1'b0;
   int   accepts_seen = 0;
   int   accepts_exp = 0;

   function automatic logic [14:0] pk(input logic rdy, input logic isel, input logic en,
                                      input int rnd, input logic xd, input logic kb,
                                      input logic ke, input logic ds, input logic cv,
                                      input logic tg, input logic bz, input logic dn);
      return {rdy, isel, en, 4'(rnd), xd, kb, ke, ds, cv, tg, bz, dn};
   endfunction

   task automatic check(input string tag, input logic [14:0] exp);
      compares++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic st, input logic ae, input logic v, input logic l,
                       input logic rs, input logic rv, input logic [14:0] exp);
      rec_t r;
      r.start = st; r.ae = ae; r.valid = v; r.last = l; r.rs = rs; r.rv = rv; r.exp = exp;
      q.push_back(r);
   endtask

   // One AEAD message: nad AD blocks, ntx text blocks, random bubbles before each block.
   task automatic gen_msg(input bit ae, input int nad, input int ntx, input int idle_gap,
                          input int maxgap);
      repeat (idle_gap) push(0, 0, 0, 0, 0, 0, '0);
      push(1, ae, 0, 0, 0, 0, '0);
      push(0, 0, 0, 0, 1, 1, pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int r = 0; r < 12; r++)
         push(0, 0, 0, 0, 1, 1, pk(0, 0, 1, r, 0, 0, r == 11, (r == 11) && ae, 0, 0, 1, 0));
      for (int i = 0; i < nad; i++) begin
         bit l = (i == nad - 1);
         repeat (hold ? 0 : $urandom_range(0, maxgap))
            push(0, 0, 0, 0, 1, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         push(0, 0, 1, l, 1, 0, pk(1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0));
         for (int r = 5; r < 12; r++)
            push(0, 0, 0, 0, 1, 1, pk(0, 0, 1, r, 0, 0, 0, (r == 11) && l, 0, 0, 1, 0));
      end
      for (int i = 0; i < ntx; i++) begin
         bit l = (i == ntx - 1);
         repeat (hold ? 0 : $urandom_range(0, maxgap))
            push(0, 0, 0, 0, 1, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         if (!l) begin
            push(0, 0, 1, 0, 1, 0, pk(1, 0, 1, 4, 1, 0, 0, 0, 1, 0, 1, 0));
            for (int r = 5; r < 12; r++)
               push(0, 0, 0, 0, 1, 1, pk(0, 0, 1, r, 0, 0, 0, 0, 0, 0, 1, 0));
         end else begin
            push(0, 0, 1, 1, 1, 0, pk(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0));
            for (int r = 1; r < 12; r++)
               push(0, 0, 0, 0, 1, 1, pk(0, 0, 1, r, 0, 0, r == 11, 0, 0, 0, 1, 0));
         end
      end
      push(0, 0, 0, 0, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      accepts_exp += nad + ntx;
   endtask

   task automatic run_trace();
      rec_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(posedge clock_i);
         #1;
         start_i       = r.rs ? 1'($urandom) : r.start;
         ad_empty_i    = (r.start && !r.rs) ? r.ae : 1'($urandom);
         block_valid_i = r.rv ? (hold ? 1'b1 : 1'($urandom)) : r.valid;
         block_last_i  = block_valid_i && !r.rv ? r.last : 1'($urandom);
         @(negedge clock_i);
         if (block_valid_i && block_ready_o) accepts_seen++;
         check($sformatf("msg%0d_cyc", msg_no), r.exp);
      end
      msg_no++;
   endtask

   initial begin
      // Reset state
      #2 check("reset_async", '0);
      @(negedge clock_i);
      check("reset_state", '0);
      resetb_i = 1'b1;

      // Abort during INIT_RND round 6
      @(posedge clock_i); #1;
      start_i = 1'b1; ad_empty_i = 1'b0;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      @(negedge clock_i);
      check("init_load", pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      repeat (7) begin
         @(posedge clock_i); #1;
      end
      @(negedge clock_i);
      check("init_rnd6", pk(0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 0));
      #1 resetb_i = 1'b0;
      #1 check("abort_async", '0);
      @(posedge clock_i); #1 resetb_i = 1'b1;
      repeat (3) begin
         @(negedge clock_i);
         check("after_abort_idle", '0);
         @(posedge clock_i); #1;
      end

      // Directed: empty AD, single last text block
      gen_msg(1'b1, 0, 1, 0, 0); run_trace();
      // Directed: 2 AD + 2 text, back-to-back start right after done
      gen_msg(1'b0, 2, 2, 0, 2); run_trace();
      // Directed: valid held high continuously
      hold = 1'b1;
      gen_msg(1'b0, 3, 3, 1, 0); run_trace();
      hold = 1'b0;
      // Random messages
      for (int m = 0; m < 12; m++) begin
         bit ae = 1'($urandom);
         hold = ($urandom_range(0, 3) == 0);
         gen_msg(ae, ae ? 0 : $urandom_range(1, 3), $urandom_range(1, 3),
                 $urandom_range(0, 2), 3);
         run_trace();
      end
      hold = 1'b0;

      compares++;
      assert (accepts_seen === accepts_exp) else begin
         errs++;
         $error("FAIL accept_count observed=%0d expected=%0d", accepts_seen, accepts_exp);
      end

      @(posedge clock_i); #1;
      start_i = 1'b0; block_valid_i = 1'b0;
      @(negedge clock_i);
      check("final_idle", '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
      $finish;
   end

endmodule
